dffre_skid_slice: RTL and testbench

//  Two-entry valid/ready register slice (skid buffer): the consumer-side counterpart of the

---
 rtl/dffre_skid_slice.sv | 105 ++++++++++
 tb/tb_dffre_skid_slice.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dffre_skid_slice.sv
// Two-entry valid/ready skid slice: registered s_ready and m_valid/m_data give full
// throughput while cutting the combinational ready path between producer and consumer.
module dffre_skid_slice #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             s_ready_q;
    logic             s_ready_d;
    logic             s_xfer_c;
    logic             m_xfer_c;

    assign s_xfer_c = s_valid & s_ready_q;
    assign m_xfer_c = m_valid & m_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (s_xfer_c) state_d = BUSY;
            end
            BUSY: begin
                if (s_xfer_c && !m_xfer_c)      state_d = FULL;
                else if (!s_xfer_c && m_xfer_c) state_d = EMPTY;
            end
            FULL: begin
                if (m_ready) state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath and ready next values
    always_comb begin
        main_d    = main_q;
        skid_d    = skid_q;
        s_ready_d = (state_d != FULL);
        case (state_q)
            EMPTY: begin
                if (s_xfer_c) main_d = s_data;
            end
            BUSY: begin
                if (s_xfer_c && m_xfer_c)       main_d = s_data;
                else if (s_xfer_c && !m_xfer_c) skid_d = s_data;
            end
            FULL: begin
                if (m_ready) main_d = skid_q;
            end
            default: begin
                main_d = main_q;
            end
        endcase
    end

    // Datapath registers; reset discards any held words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q    <= RESET_VALUE;
            skid_q    <= RESET_VALUE;
            s_ready_q <= 1'b0;
        end else begin
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = (state_q != EMPTY);
    assign m_data  = main_q;
    assign count   = state_q;

endmodule

// File: tb/tb_dffre_skid_slice.sv
// Bench for dffre_skid_slice: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_dffre_skid_slice;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] q[$];
    logic             exp_sready = 1'b0;
    logic [WIDTH-1:0] exp_mdata  = '0;

    dffre_skid_slice #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two words with a one-edge-late ready flag
    always @(posedge clk) begin
        bit s_x;
        bit m_x;
        if (!rst_n) begin
            q.delete();
            exp_sready = 1'b0;
            exp_mdata  = 8'h00;
            chk_en     = 1'b1;
        end else begin
            s_x = s_valid && exp_sready;
            m_x = (q.size() != 0) && m_ready;
            if (m_x) void'(q.pop_front());
            if (s_x) q.push_back(s_data);
            exp_sready = (q.size() != 2);
            if (q.size() != 0) exp_mdata = q[0];
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("count",   32'(count),   32'(q.size()));
            chk("s_ready", 32'(s_ready), 32'(exp_sready));
            chk("m_data",  32'(m_data),  32'(exp_mdata));
        end
    end

    task automatic step(input logic r, input logic sv, input logic [WIDTH-1:0] d, input logic mr);
        rst_n   = r;
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic mv, input logic sr,
                              input logic [1:0] cnt, input logic [WIDTH-1:0] md);
        chk({name, ".m_valid"}, 32'(m_valid), 32'(mv));
        chk({name, ".s_ready"}, 32'(s_ready), 32'(sr));
        chk({name, ".count"},   32'(count),   32'(cnt));
        chk({name, ".m_data"},  32'(m_data),  32'(md));
    endtask

    initial begin
        // Reset held for three edges with s_valid high
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hFF, 1'b1);
            expect_out("reset", 1'b0, 1'b0, 2'd0, 8'h00);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("release", 1'b0, 1'b1, 2'd0, 8'h00);

        // Streaming at one word per cycle
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b1);
            expect_out("stream", 1'b1, 1'b1, 2'd1, 8'(i));
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("stream_end", 1'b0, 1'b1, 2'd0, 8'h10);

        // Backpressure into the skid register
        step(1'b1, 1'b1, 8'hA0, 1'b1);
        expect_out("bp0", 1'b1, 1'b1, 2'd1, 8'hA0);
        step(1'b1, 1'b1, 8'hA1, 1'b0);
        expect_out("bp_skid", 1'b1, 1'b0, 2'd2, 8'hA0);
        step(1'b1, 1'b1, 8'hA2, 1'b0);
        expect_out("bp_hold", 1'b1, 1'b0, 2'd2, 8'hA0);
        step(1'b1, 1'b1, 8'hA2, 1'b1);
        expect_out("bp_a1", 1'b1, 1'b1, 2'd1, 8'hA1);
        step(1'b1, 1'b1, 8'hA2, 1'b1);
        expect_out("bp_a2", 1'b1, 1'b1, 2'd1, 8'hA2);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("bp_empty", 1'b0, 1'b1, 2'd0, 8'hA2);

        // Single-word drain
        step(1'b1, 1'b1, 8'h5A, 1'b1);
        expect_out("drain_v", 1'b1, 1'b1, 2'd1, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("drain_e", 1'b0, 1'b1, 2'd0, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("drain_k", 1'b0, 1'b1, 2'd0, 8'h5A);

        // Reset while FULL discards both words
        step(1'b1, 1'b1, 8'h11, 1'b0);
        expect_out("mid_1", 1'b1, 1'b1, 2'd1, 8'h11);
        step(1'b1, 1'b1, 8'h22, 1'b0);
        expect_out("mid_full", 1'b1, 1'b0, 2'd2, 8'h11);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        expect_out("mid_rst", 1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            expect_out("mid_idle", 1'b0, 1'b1, 2'd0, 8'h00);
        end
        step(1'b1, 1'b1, 8'h44, 1'b1);
        expect_out("mid_new", 1'b1, 1'b1, 2'd1, 8'h44);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        expect_out("mid_done", 1'b0, 1'b1, 2'd0, 8'h44);

        // Random traffic, checked by the model each cycle
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
